// File: rtl/dcount_pkg.sv
// dcount_pkg: shared widths and IRQ FSM state encoding for the down-counter event monitor.
package dcount_pkg;
  localparam int DCNT_WIDTH = 8;
  localparam int DCNT_EVT_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PEND  = 2'd2
  } state_e;
endpackage

// File: rtl/dcount_edge_detect.sv
// dcount_edge_detect: remembers the previous count and flags raw wrap and compare-arrival conditions.
module dcount_edge_detect
  import dcount_pkg::*;
#(
  parameter int WIDTH = DCNT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] cmp_i,
  output logic             unf_o,
  output logic             match_o
);
  logic [WIDTH-1:0] prev_count_q;
  logic             prev_valid_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_count_q <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_count_q <= count_i;
      prev_valid_q <= 1'b1;
    end
  end
  // a held count never re-matches, so a cmp change onto a stalled counter is silent
  assign unf_o   = prev_valid_q && (prev_count_q == '0) && (count_i == {WIDTH{1'b1}});
  assign match_o = prev_valid_q && (count_i == cmp_i) && (count_i != prev_count_q);
endmodule

// File: rtl/dcount_event_monitor.sv
// dcount_event_monitor: turns the sampled down-count into underflow/match pulses,
// a saturating underflow count and an acknowledged interrupt with overrun tracking.
module dcount_event_monitor
  import dcount_pkg::*;
#(
  parameter int WIDTH = DCNT_WIDTH,
  parameter int EVT_W = DCNT_EVT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] cmp_value,
  input  logic             irq_en,
  input  logic             irq_ack,
  output logic             underflow,
  output logic             match,
  output logic [EVT_W-1:0] event_count,
  output logic             irq,
  output logic             overrun
);
  logic             unf_raw, match_raw;
  logic             underflow_q, match_q;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             overrun_q, overrun_d;
  state_e           state_q, state_d;
  dcount_edge_detect #(.WIDTH(WIDTH)) u_edge (
    .clock   (clock),
    .reset   (reset),
    .count_i (count_in),
    .cmp_i   (cmp_value),
    .unf_o   (unf_raw),
    .match_o (match_raw)
  );
  always_comb begin
    evt_d     = (underflow_q && evt_q != {EVT_W{1'b1}}) ? evt_q + EVT_W'(1) : evt_q;
    overrun_d = irq_ack ? 1'b0 : (underflow_q && state_q == ST_PEND) ? 1'b1 : overrun_q;
    state_d   = state_q;
    if (!irq_en) state_d = ST_IDLE;
    else if (state_q == ST_IDLE) state_d = ST_ARMED;
    else if (state_q == ST_ARMED) state_d = underflow_q ? ST_PEND : ST_ARMED;
    else if (state_q == ST_PEND) state_d = (irq_ack && !underflow_q) ? ST_ARMED : ST_PEND;
    else state_d = ST_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_q <= 1'b0;
      match_q     <= 1'b0;
      evt_q       <= '0;
      overrun_q   <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      underflow_q <= unf_raw;
      match_q     <= match_raw;
      evt_q       <= evt_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
    end
  end
  assign underflow   = underflow_q;
  assign match       = match_q;
  assign event_count = evt_q;
  assign irq         = (state_q == ST_PEND);
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_dcount_event_monitor.sv
// tb_dcount_event_monitor: directed down-count stimulus with a pulse scoreboard and level checks.
module tb_dcount_event_monitor;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] count_in, cmp_value;
  logic       irq_en, irq_ack;
  logic       underflow, match, irq, overrun;
  logic [7:0] event_count;
  logic       underflow2, match2, irq2, overrun2;
  logic [1:0] event_count2;
  logic [7:0] cnt;
  logic [1:0] exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clock = ~clock;

  dcount_event_monitor dut (
    .clock(clock), .reset(reset), .count_in(count_in), .cmp_value(cmp_value),
    .irq_en(irq_en), .irq_ack(irq_ack), .underflow(underflow), .match(match),
    .event_count(event_count), .irq(irq), .overrun(overrun)
  );

  dcount_event_monitor #(.WIDTH(8), .EVT_W(2)) dut2 (
    .clock(clock), .reset(reset), .count_in(count_in), .cmp_value(cmp_value),
    .irq_en(1'b0), .irq_ack(1'b0), .underflow(underflow2), .match(match2),
    .event_count(event_count2), .irq(irq2), .overrun(overrun2)
  );

  always @(negedge clock) begin
    if (underflow || match) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected: got uf=%0b mt=%0b, required no pulse", underflow, match);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({underflow, match} !== e) begin
          n_fail++;
          $display("FAIL pulse_kind: got uf/mt=%b required %b", {underflow, match}, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  task automatic run(input int n);
    logic [7:0] nx;
    logic       w, m;
    for (int i = 0; i < n; i++) begin
      nx = cnt - 8'd1;
      w  = (cnt == 8'h00) && (nx == 8'hFF);
      m  = (nx == cmp_value);
      if (w || m) exp_q.push_back({w, m});
      cnt = nx;
      count_in = nx;
      cyc();
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wrap();
    run(255);
    run(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; count_in = 8'h00; cmp_value = 8'hF0; irq_en = 1'b0; irq_ack = 1'b0; cnt = 8'h00;
    hold(2);
    chk("rst_underflow", underflow, 0);
    chk("rst_match", match, 0);
    chk("rst_event_count", event_count, 0);
    chk("rst_irq", irq, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0; irq_en = 1'b1;
    hold(2);
    run(1);
    chk("first_wrap_pulse", underflow, 1);
    chk("first_wrap_cnt_before", event_count, 0);
    chk("first_wrap_irq_before", irq, 0);
    cyc();
    chk("first_wrap_pulse_end", underflow, 0);
    chk("first_wrap_event_count", event_count, 1);
    chk("first_wrap_irq", irq, 1);
    run(15);
    chk("match_pulse", match, 1);
    hold(10);
    chk("match_held", match, 0);
    cmp_value = 8'h33; hold(2);
    cmp_value = 8'hF0; hold(2);
    chk("match_cmp_change", match, 0);
    run(240);
    run(1);
    cyc();
    chk("overrun_set", overrun, 1);
    chk("overrun_irq", irq, 1);
    chk("overrun_event_count", event_count, 2);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    chk("ack_irq", irq, 0);
    chk("ack_overrun", overrun, 0);
    wrap();
    cyc();
    chk("repend_irq", irq, 1);
    chk("repend_event_count", event_count, 3);
    wrap();
    cyc();
    chk("overrun_again", overrun, 1);
    wrap();
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    chk("ack_with_uf_irq", irq, 1);
    chk("ack_with_uf_overrun", overrun, 0);
    chk("ack_with_uf_event_count", event_count, 5);
    run(255);
    reset = 1'b1; cyc();
    chk("midrst_irq", irq, 0);
    chk("midrst_event_count", event_count, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_dut2_event_count", event_count2, 0);
    reset = 1'b0; count_in = 8'hFF; cnt = 8'hFF;
    hold(3);
    chk("release_ff_underflow", underflow, 0);
    chk("release_ff_event_count", event_count, 0);
    repeat (5) wrap();
    hold(2);
    chk("sat_event_count", event_count2, 3);
    chk("sat_irq", irq2, 0);
    chk("sat_overrun", overrun2, 0);
    chk("main_event_count", event_count, 5);
    chk("main_irq", irq, 1);
    chk("main_overrun", overrun, 1);
    hold(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcount_event_monitor.md
Name: dcount_event_monitor

Overview:
- Downstream consumer of the 8-bit synchronous down counter (syndcounter8).
- Samples the counter's count_out each clock and detects underflow (wrap 0x00 -> max) and compare-match events.
- Counts underflows and raises a pending interrupt with an ack handshake.
- Sits between the counter and the control/CPU side; turns the raw count into timer events.

Parameters:
- WIDTH, 8, width of the sampled count; must equal the counter width.
- EVT_W, 8, width of the saturating underflow event counter.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- count_in  in  WIDTH  counter value, wired from the counter's count_out.
- cmp_value  in  WIDTH  compare value; sampled every cycle.
- irq_en  in  1  interrupt enable level.
- irq_ack  in  1  one-cycle acknowledge of a pending interrupt.
- underflow  out  1  one-cycle pulse per detected wrap.
- match  out  1  one-cycle pulse when the count newly equals cmp_value.
- event_count  out  EVT_W  saturating count of underflows.
- irq  out  1  interrupt pending level.
- overrun  out  1  sticky flag: an underflow occurred while irq was pending.

Behaviour:
- Reset: one clock; the reset is synchronous and active-high.
  - Internal state on reset: prev_count=0, prev_valid=0, state=IDLE.
  - Outputs on reset: underflow=0, match=0, event_count=0, irq=0, overrun=0.
  - Reset asserted mid-operation clears everything on that edge. Pending irq is dropped.
- Sampling: prev_count<=count_in every cycle. prev_valid<=1 on the first non-reset cycle.
- Underflow condition: prev_valid && prev_count==0 && count_in=={WIDTH{1}}.
  - underflow is registered: high in the cycle after the condition is visible on count_in (latency 1).
- Match condition: prev_valid && count_in==cmp_value && count_in!=prev_count.
  - Fires once per arrival; holding count (enable low) does not repeat it.
  - Registered, latency 1.
  - A change of cmp_value onto the held count does not fire.
- No event is generated on the first cycle after reset (prev_valid=0).
- event_count: +1 on each registered underflow pulse. Saturates at 2^EVT_W-1 with no wrap. Cleared only by reset.
- IRQ FSM, 2-bit state:
  - IDLE: irq=0. Go to ARMED when irq_en=1.
  - ARMED: irq=0. Go to PEND on an underflow pulse. Go to IDLE if irq_en=0.
  - PEND: irq=1. Go to ARMED on irq_ack. Go to IDLE if irq_en=0 (irq drops, overrun kept).
  - irq is registered from state: it rises the cycle after the underflow pulse.
- Overrun: an underflow pulse while in PEND without irq_ack in the same cycle sets overrun.
- Ack and underflow in the same cycle while in PEND:
  - Stay in PEND (new event re-pends).
  - overrun is not set.
  - overrun is cleared.
- irq_ack clears overrun in any state. irq_ack in IDLE/ARMED has no other effect.
- irq_en=0 with an underflow: event_count still increments; no state change.
- Arithmetic: all compares unsigned, WIDTH bits. event_count saturates via compare-to-max, never overflow.

Decomposition:
- Shared package dcount_pkg holds:
  - FSM state encodings ST_IDLE=2'd0, ST_ARMED=2'd1, ST_PEND=2'd2.
  - Default widths DCNT_WIDTH=8, DCNT_EVT_W=8.
- One natural sub-module: dcount_edge_detect. It holds prev_count/prev_valid and produces the raw underflow and match conditions.
- The top level holds the event counter and the IRQ FSM.

Test Plan:
- Reset, then enable the counter from 0x00 with irq_en=1 -> count_in goes 0x00->0xFF:
  - underflow pulses for 1 cycle, 1 cycle later.
  - event_count=1.
  - irq rises the following cycle.
- Reset asserted while count_in=0x00, released with count_in=0xFF -> no underflow; event_count stays 0.
- cmp_value=0xF0, counter counting down from 0xFF -> match pulses exactly once when count_in reaches 0xF0.
  - Enable low holding 0xF0 for 10 cycles -> no further match.
- irq pending, second wrap after 256 counts with no ack -> overrun=1, irq stays 1, event_count=2.
  - irq_ack -> irq=0, overrun=0.
- irq_ack in the same cycle as an underflow pulse while in PEND -> irq stays 1, overrun=0.
- EVT_W=2, force 5 wraps -> event_count saturates at 3.
  - irq_en=0 throughout -> irq stays 0.
